// File: rtl/inst_fetch_bridge_pkg.sv
// Shared encodings for the IF-stage fetch bridge: FSM states, AXI constants, AR payload.
package inst_fetch_bridge_pkg;

  localparam int unsigned STATE_W = 5;

  // One-hot FSM states
  localparam logic [STATE_W-1:0] S_IDLE  = 5'b00001;
  localparam logic [STATE_W-1:0] S_CHECK = 5'b00010;
  localparam logic [STATE_W-1:0] S_AR    = 5'b00100;
  localparam logic [STATE_W-1:0] S_R     = 5'b01000;
  localparam logic [STATE_W-1:0] S_RESP  = 5'b10000;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // AR channel payload (ID is parameter-sized and driven separately)
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

endpackage

// File: rtl/inst_fetch_bridge_line_buf.sv
// Single-line fetch buffer: word storage with one write port, combinational read, tag and valid.
module inst_fetch_bridge_line_buf
  import inst_fetch_bridge_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned OFF_W      = 2,
  parameter int unsigned TAG_W      = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             fill_done,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             fill_ok,
  input  logic             inv,
  input  logic [OFF_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] tag,
  output logic             valid
);

  logic [31:0] words [LINE_WORDS];

  // Refill beats land here one word per accepted beat
  always_ff @(posedge clk) begin
    if (wr_en) begin
      words[wr_idx] <= wr_data;
    end
  end

  // Tag/valid update at end of fill; invalidate wins over a same-cycle validate
  always_ff @(posedge clk) begin
    if (reset) begin
      tag   <= '0;
      valid <= 1'b0;
    end else begin
      if (fill_done) begin
        tag   <= fill_tag;
        valid <= fill_ok;
      end
      if (inv) begin
        valid <= 1'b0;
      end
    end
  end

  assign rd_data = words[rd_idx];

endmodule

// File: rtl/inst_fetch_bridge.sv
// IF-stage instruction fetch responder: one fetch in flight, single-line buffer hits, AXI reads on miss.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic            inst_op,
  input  logic [31:0]     inst_addr,
  input  logic            inst_uncache_en,
  input  logic            inst_cancel,
  input  logic            inst_inv,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [31:0]     inst_rdata,
  output logic            icache_miss,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 30 - OFF_W;

  logic [STATE_W-1:0] state_q, state_d;
  logic [31:0]        addr_q;
  logic               unc_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [31:0]        cap_q;
  logic               inv_seen_q;
  logic               err_seen_q;

  logic [31:0]        buf_rdata;
  logic [TAG_W-1:0]   buf_tag;
  logic               buf_valid;

  logic [OFF_W-1:0]   word_idx;
  logic [TAG_W-1:0]   addr_tag;
  logic [OFF_W-1:0]   cap_idx;
  logic               hit;
  logic               beat;
  logic               beat_err;
  logic               buf_wr;
  logic               fill_done;
  logic               fill_ok;
  ar_req_t            ar_req;
  logic               unused_inputs;

  // Request is a read regardless of op; rid needs no check with one outstanding read
  assign unused_inputs = ^{inst_op, rid, inst_addr[1:0]};

  assign word_idx  = addr_q[OFF_W+1:2];
  assign addr_tag  = addr_q[31:OFF_W+2];
  assign cap_idx   = unc_q ? '0 : word_idx;
  assign hit       = !unc_q && buf_valid && (buf_tag == addr_tag);
  assign beat      = (state_q == S_R) && rvalid;
  assign beat_err  = (rresp != 2'b00);
  assign buf_wr    = beat && !unc_q;
  assign fill_done = beat && rlast && !unc_q;
  assign fill_ok   = !inv_seen_q && !inst_inv && !err_seen_q && !beat_err;

  // AR payload derives only from latched request state, so it holds until arready
  always_comb begin
    ar_req.addr  = unc_q ? addr_q : {addr_tag, (OFF_W+2)'(0)};
    ar_req.len   = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);
    ar_req.size  = AXI_SIZE_4B;
    ar_req.burst = AXI_BURST_INCR;
  end

  assign arid    = ID_W'(AXI_ID);
  assign araddr  = ar_req.addr;
  assign arlen   = ar_req.len;
  assign arsize  = ar_req.size;
  assign arburst = ar_req.burst;

  inst_fetch_bridge_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_q),
    .wr_data   (rdata),
    .fill_done (fill_done),
    .fill_tag  (addr_tag),
    .fill_ok   (fill_ok),
    .inv       (inst_inv),
    .rd_idx    (word_idx),
    .rd_data   (buf_rdata),
    .tag       (buf_tag),
    .valid     (buf_valid)
  );

  // State register plus request latch, beat counter, capture and fill-status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      unc_q      <= 1'b0;
      cnt_q      <= '0;
      cap_q      <= '0;
      inv_seen_q <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && inst_valid) begin
        addr_q <= {inst_addr[31:2], 2'b00};
        unc_q  <= inst_uncache_en;
      end
      if ((state_q == S_AR) && arready) begin
        cnt_q      <= '0;
        inv_seen_q <= 1'b0;
        err_seen_q <= 1'b0;
      end
      if ((state_q == S_R) && inst_inv) begin
        inv_seen_q <= 1'b1;
      end
      if (beat) begin
        cnt_q <= cnt_q + OFF_W'(1);
        if (cnt_q == cap_idx) begin
          cap_q <= rdata;
        end
        if (beat_err) begin
          err_seen_q <= 1'b1;
        end
      end
    end
  end

  // Next-state and handshake/response outputs
  always_comb begin
    state_d      = state_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    icache_miss  = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        inst_addr_ok = 1'b1;
        if (inst_valid) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (inst_cancel) begin
          state_d = S_IDLE;
        end else if (hit) begin
          inst_data_ok = 1'b1;
          inst_rdata   = buf_rdata;
          state_d      = S_IDLE;
        end else begin
          state_d = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        inst_data_ok = 1'b1;
        inst_rdata   = cap_q;
        icache_miss  = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: scoreboarded responses, AXI slave model, per-scenario tasks.
module tb_inst_fetch_bridge;

  localparam int unsigned LW  = 4;
  localparam int unsigned IDW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            inst_valid = 1'b0;
  logic            inst_op = 1'b0;
  logic [31:0]     inst_addr = '0;
  logic            inst_uncache_en = 1'b0;
  logic            inst_cancel = 1'b0;
  logic            inst_inv = 1'b0;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [31:0]     inst_rdata;
  logic            icache_miss;
  logic [IDW-1:0]  arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  always #5 clk = ~clk;

  inst_fetch_bridge #(
    .LINE_WORDS (LW),
    .ID_W       (IDW),
    .AXI_ID     (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_valid      (inst_valid),
    .inst_op         (inst_op),
    .inst_addr       (inst_addr),
    .inst_uncache_en (inst_uncache_en),
    .inst_cancel     (inst_cancel),
    .inst_inv        (inst_inv),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .icache_miss     (icache_miss),
    .arid            (arid),
    .araddr          (araddr),
    .arlen           (arlen),
    .arsize          (arsize),
    .arburst         (arburst),
    .arvalid         (arvalid),
    .arready         (arready),
    .rid             (rid),
    .rdata           (rdata),
    .rresp           (rresp),
    .rlast           (rlast),
    .rvalid          (rvalid),
    .rready          (rready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        miss;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  resp_t   sb[$];
  ar_exp_t arq[$];
  bit [31:0] mem [bit [31:0]];

  // Bench model of the fetch buffer
  logic        m_valid = 1'b0;
  logic [27:0] m_tag = '0;
  logic [31:0] m_line [LW];

  int ar_delay = 0;
  int err_beat = -1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5a5a_0000;
  endfunction

  // Response monitor: pops the scoreboard on every data_ok
  initial begin
    forever begin
      resp_t got;
      resp_t exp;
      @(negedge clk);
      if (!reset && inst_data_ok) begin
        got.data = inst_rdata;
        got.miss = icache_miss;
        n_checks++;
        if (inst_addr_ok !== 1'b0)
          $display("FAIL resp_overlap: addr_ok=%b with data_ok, required 0", inst_addr_ok);
        else
          n_pass++;
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL resp_unexpected: data_ok rdata=%h miss=%b, required no response", got.data, got.miss);
        end else begin
          exp = sb.pop_front();
          if (got !== exp)
            $display("FAIL resp: rdata=%h miss=%b, required rdata=%h miss=%b", got.data, got.miss, exp.data, exp.miss);
          else
            n_pass++;
        end
      end
    end
  end

  // AXI read slave: checks AR against expectations, optional stall, returns beats from mem
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    forever begin
      ar_exp_t     e;
      logic [31:0] a0;
      logic [7:0]  l0;
      @(negedge clk);
      if (reset || !arvalid) continue;
      a0 = araddr;
      l0 = arlen;
      n_checks++;
      if (arq.size() == 0) begin
        $display("FAIL ar_unexpected: arvalid araddr=%h arlen=%0d, required no request", araddr, arlen);
      end else begin
        e = arq.pop_front();
        if (araddr !== e.addr || arlen !== e.len || arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0)
          $display("FAIL ar_fields: araddr=%h arlen=%0d arsize=%b arburst=%b arid=%0d, required araddr=%h arlen=%0d arsize=010 arburst=01 arid=0",
                   araddr, arlen, arsize, arburst, arid, e.addr, e.len);
        else
          n_pass++;
      end
      for (int i = 0; i < ar_delay; i++) begin
        @(negedge clk);
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== a0 || arlen !== l0)
          $display("FAIL ar_stable: arvalid=%b araddr=%h arlen=%0d, required 1 %h %0d", arvalid, araddr, arlen, a0, l0);
        else
          n_pass++;
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i <= int'(l0); i++) begin
        if (reset) break;
        rvalid = 1'b1;
        rdata  = mem_rd(a0 + 32'(4 * i));
        rresp  = (i == err_beat) ? 2'b10 : 2'b00;
        rlast  = (i == int'(l0));
        n_checks++;
        if (rready !== 1'b1)
          $display("FAIL rready_beat%0d: rready=%b, required 1", i, rready);
        else
          n_pass++;
        @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
  end

  // Issue one fetch; predicts its AR and response and updates the buffer model
  task automatic issue(input logic [31:0] a, input logic unc, input logic cancel, input logic fill_ok);
    int t;
    logic [31:0] wa;
    logic [31:0] la;
    logic hit;
    t = 0;
    while (inst_addr_ok !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      n_checks++;
      $display("FAIL issue_wait: addr_ok=%b, required 1 within 200 cycles", inst_addr_ok);
    end
    wa  = {a[31:2], 2'b00};
    la  = {a[31:4], 4'h0};
    hit = !unc && m_valid && (m_tag == a[31:4]);
    if (!cancel) begin
      if (hit) begin
        sb.push_back({m_line[a[3:2]], 1'b0});
      end else begin
        arq.push_back({(unc ? wa : la), (unc ? 8'd0 : 8'd3)});
        sb.push_back({mem_rd(wa), 1'b1});
        if (!unc) begin
          for (int i = 0; i < int'(LW); i++) m_line[i] = mem_rd(la + 32'(4 * i));
          m_tag   = a[31:4];
          m_valid = fill_ok;
        end
      end
    end
    inst_valid = 1'b1; inst_addr = a; inst_uncache_en = unc;
    @(posedge clk); #1;
    inst_valid = 1'b0; inst_cancel = cancel;
    @(posedge clk); #1;
    inst_cancel = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain and the bridge to return to idle
  task automatic wait_idle(output bit done);
    int t;
    t = 0;
    while ((sb.size() != 0 || inst_addr_ok !== 1'b1) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    done = (sb.size() == 0 && inst_addr_ok === 1'b1);
  endtask

  // Bounded wait for the R phase
  task automatic wait_rready(output bit done);
    int t;
    t = 0;
    while (rready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    done = (rready === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (inst_addr_ok !== 1'b1) $display("FAIL reset_addr_ok: %b, required 1", inst_addr_ok); else n_pass++;
    n_checks++; if (inst_data_ok !== 1'b0) $display("FAIL reset_data_ok: %b, required 0", inst_data_ok); else n_pass++;
    n_checks++; if (arvalid !== 1'b0) $display("FAIL reset_arvalid: %b, required 0", arvalid); else n_pass++;
    n_checks++; if (rready !== 1'b0) $display("FAIL reset_rready: %b, required 0", rready); else n_pass++;
    n_checks++; if (inst_rdata !== 32'h0) $display("FAIL reset_rdata: %h, required 0", inst_rdata); else n_pass++;
    n_checks++; if (icache_miss !== 1'b0) $display("FAIL reset_miss: %b, required 0", icache_miss); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    bit ok;
    mem[32'h1c00_0000] = 32'h11; mem[32'h1c00_0004] = 32'h22;
    mem[32'h1c00_0008] = 32'h33; mem[32'h1c00_000c] = 32'h44;
    issue(32'h1c00_0000, 1'b0, 1'b0, 1'b1);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL cold_miss_done: pending=%0d, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_hit();
    issue(32'h1c00_0008, 1'b0, 1'b0, 1'b1);
    n_checks++; if (sb.size() != 0) $display("FAIL hit_latency: pending=%0d after check cycle, required 0", sb.size()); else n_pass++;
    n_checks++; if (arq.size() != 0) $display("FAIL hit_no_ar: pending ar=%0d, required 0", arq.size()); else n_pass++;
  endtask

  task automatic test_uncached();
    bit ok;
    mem[32'h1c00_0004] = 32'h55;
    issue(32'h1c00_0004, 1'b1, 1'b0, 1'b1);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL uncached_done: pending=%0d, required 0", sb.size()); else n_pass++;
    issue(32'h1c00_0004, 1'b0, 1'b0, 1'b1);
    n_checks++; if (sb.size() != 0) $display("FAIL uncached_rehit: pending=%0d, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_cancel();
    issue(32'h1c00_0040, 1'b0, 1'b1, 1'b1);
    n_checks++; if (inst_addr_ok !== 1'b1) $display("FAIL cancel_addr_ok: %b, required 1", inst_addr_ok); else n_pass++;
    n_checks++; if (arvalid !== 1'b0) $display("FAIL cancel_arvalid: %b, required 0", arvalid); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (sb.size() != 0 || arq.size() != 0) $display("FAIL cancel_quiet: pending resp=%0d ar=%0d, required 0 0", sb.size(), arq.size()); else n_pass++;
  endtask

  task automatic test_inv_during_fill();
    bit ok;
    issue(32'h1c00_0010, 1'b0, 1'b0, 1'b0);
    wait_rready(ok);
    n_checks++; if (!ok) $display("FAIL inv_rready: rready=%b, required 1 within 50 cycles", rready); else n_pass++;
    inst_inv = 1'b1;
    @(posedge clk); #1;
    inst_inv = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL inv_fill_done: pending=%0d, required 0", sb.size()); else n_pass++;
    issue(32'h1c00_0014, 1'b0, 1'b0, 1'b1);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL inv_refetch_done: pending=%0d, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(32'h1c00_0018, 1'b0, 1'b0, 1'b1);
    issue(32'h1c00_001c, 1'b0, 1'b0, 1'b1);
    issue(32'h1c00_0010, 1'b0, 1'b0, 1'b1);
    n_checks++; if (sb.size() != 0 || arq.size() != 0) $display("FAIL b2b_hits: pending resp=%0d ar=%0d, required 0 0", sb.size(), arq.size()); else n_pass++;
  endtask

  task automatic test_stall_and_error();
    bit ok;
    ar_delay = 5;
    err_beat = 1;
    issue(32'h1c00_0020, 1'b0, 1'b0, 1'b0);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL err_fill_done: pending=%0d, required 0", sb.size()); else n_pass++;
    ar_delay = 0;
    err_beat = -1;
    issue(32'h1c00_0024, 1'b0, 1'b0, 1'b1);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL err_refetch_done: pending=%0d, required 0", sb.size()); else n_pass++;
    issue(32'h1c00_0028, 1'b0, 1'b0, 1'b1);
    n_checks++; if (sb.size() != 0) $display("FAIL err_then_hit: pending=%0d, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    issue(32'h1c00_0030, 1'b0, 1'b0, 1'b1);
    wait_rready(ok);
    n_checks++; if (!ok) $display("FAIL rst_rready: rready=%b, required 1 within 50 cycles", rready); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (arvalid !== 1'b0) $display("FAIL rst_arvalid: %b, required 0", arvalid); else n_pass++;
    n_checks++; if (rready !== 1'b0) $display("FAIL rst_rready_low: %b, required 0", rready); else n_pass++;
    n_checks++; if (inst_data_ok !== 1'b0) $display("FAIL rst_data_ok: %b, required 0", inst_data_ok); else n_pass++;
    sb.delete();
    m_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (inst_addr_ok !== 1'b1) $display("FAIL rst_addr_ok: %b, required 1", inst_addr_ok); else n_pass++;
    issue(32'h1c00_0030, 1'b0, 1'b0, 1'b1);
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL rst_recover_done: pending=%0d, required 0", sb.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_uncached();
    test_cancel();
    test_inv_during_fill();
    test_back_to_back();
    test_stall_and_error();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0 || arq.size() != 0)
      $display("FAIL final_drain: pending resp=%0d ar=%0d, required 0 0", sb.size(), arq.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
